// File: rtl/gain_ramp_sat.sv
// gain_ramp_sat: per-band power-of-two gain stage for the 5-band equaliser.
// Shifts each sample left (boost, saturating) or right (attenuate, floor)
// by the currently applied gain. The applied gain walks one 6 dB step at a
// time toward the requested target, one step per RAMP_LEN valid samples,
// so gain changes never produce an audible click.
module gain_ramp_sat #(
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 4,
    parameter int MAX_BOOST = 3,
    parameter int MAX_ATT   = 4,
    parameter int RAMP_LEN  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_wave,
    input  logic [GAIN_W-1:0] i_gain,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_wave,
    output logic              o_sat,
    output logic              o_ramping,
    output logic [GAIN_W-1:0] o_cur_gain
);

    // Boost needs MAX_BOOST guard bits so the unsaturated product is exact.
    localparam int PROD_W = DATA_W + MAX_BOOST;
    localparam int CNT_W  = (RAMP_LEN > 1) ? $clog2(RAMP_LEN) : 1;

    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(RAMP_LEN - 1);
    localparam logic signed [GAIN_W-1:0] GAIN_HI  = GAIN_W'(MAX_BOOST);
    localparam logic signed [GAIN_W-1:0] GAIN_LO  = GAIN_W'(-MAX_ATT);

    // Largest / smallest DATA_W values, expressed in the wide product domain.
    localparam logic signed [PROD_W-1:0] SAT_HI =
        {{(MAX_BOOST + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_LO =
        {{(MAX_BOOST + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
    localparam logic [DATA_W-1:0] WAVE_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] WAVE_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } state_t;

    // Gain control state
    state_t                   state_q, state_d;
    logic signed [GAIN_W-1:0] curGain_q, curGain_d;
    logic [CNT_W-1:0]         rampCnt_q, rampCnt_d;
    logic                     ramping_q, ramping_d;
    logic signed [GAIN_W-1:0] gainIn;
    logic signed [GAIN_W-1:0] tgtGain;
    logic signed [GAIN_W-1:0] stepGain;

    // Stage 1: captured sample plus the gain that was in force when it arrived
    logic                     s1Valid_q;
    logic [DATA_W-1:0]        s1Wave_q;
    logic signed [GAIN_W-1:0] s1Gain_q;

    // Stage 2a: shifted sample, still at full product width
    logic signed [PROD_W-1:0] waveExt;
    logic signed [PROD_W-1:0] shifted;
    logic [GAIN_W-1:0]        shAmt;
    logic                     s2Valid_q;
    logic signed [PROD_W-1:0] s2Prod_q;

    // Stage 2b: clamped result, which is what leaves the block
    logic [DATA_W-1:0]        satWave;
    logic                     satFlag;
    logic                     oValid_q;
    logic [DATA_W-1:0]        oWave_q;
    logic                     oSat_q;

    // Clamp the requested shift into the range the datapath supports.
    always_comb begin
        gainIn  = $signed(i_gain);
        tgtGain = gainIn;
        if (gainIn > GAIN_HI) begin
            tgtGain = GAIN_HI;
        end else if (gainIn < GAIN_LO) begin
            tgtGain = GAIN_LO;
        end
    end

    // Ramp FSM next state: step the applied gain toward the target once the
    // counter has seen RAMP_LEN valid samples, then pick the new direction.
    always_comb begin
        state_d   = state_q;
        curGain_d = curGain_q;
        rampCnt_d = rampCnt_q;
        stepGain  = curGain_q;
        unique case (state_q)
            IDLE: begin
                rampCnt_d = '0;
                if (tgtGain > curGain_q) begin
                    state_d = RAMP_UP;
                end else if (tgtGain < curGain_q) begin
                    state_d = RAMP_DN;
                end
            end
            RAMP_UP, RAMP_DN: begin
                if (i_valid) begin
                    if (rampCnt_q == CNT_LAST) begin
                        rampCnt_d = '0;
                        if (tgtGain > curGain_q) begin
                            stepGain = curGain_q + GAIN_W'(1);
                        end else if (tgtGain < curGain_q) begin
                            stepGain = curGain_q - GAIN_W'(1);
                        end
                        curGain_d = stepGain;
                        if (tgtGain > stepGain) begin
                            state_d = RAMP_UP;
                        end else if (tgtGain < stepGain) begin
                            state_d = RAMP_DN;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rampCnt_d = rampCnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                rampCnt_d = '0;
            end
        endcase
        ramping_d = (state_d != IDLE);
    end

    // Ramp FSM registers; o_ramping is registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            curGain_q <= '0;
            rampCnt_q <= '0;
            ramping_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            curGain_q <= curGain_d;
            rampCnt_q <= rampCnt_d;
            ramping_q <= ramping_d;
        end
    end

    // Stage 1: capture the sample with the pre-step gain.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1Valid_q <= 1'b0;
            s1Wave_q  <= '0;
            s1Gain_q  <= '0;
        end else begin
            s1Valid_q <= i_valid;
            if (i_valid) begin
                s1Wave_q <= i_wave;
                s1Gain_q <= curGain_q;
            end
        end
    end

    // Shift in the wide domain: left for boost, arithmetic right for cut.
    always_comb begin
        waveExt = {{MAX_BOOST{s1Wave_q[DATA_W-1]}}, s1Wave_q};
        shAmt   = '0;
        shifted = waveExt;
        if (s1Gain_q > 0) begin
            shAmt   = s1Gain_q;
            shifted = waveExt <<< shAmt;
        end else if (s1Gain_q < 0) begin
            shAmt   = -s1Gain_q;
            shifted = waveExt >>> shAmt;
        end
    end

    // Stage 2a: register the exact shifted value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2Valid_q <= 1'b0;
            s2Prod_q  <= '0;
        end else begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Prod_q <= shifted;
            end
        end
    end

    // Clip anything outside the DATA_W range and flag it.
    always_comb begin
        satWave = s2Prod_q[DATA_W-1:0];
        satFlag = 1'b0;
        if (s2Prod_q > SAT_HI) begin
            satWave = WAVE_MAX;
            satFlag = 1'b1;
        end else if (s2Prod_q < SAT_LO) begin
            satWave = WAVE_MIN;
            satFlag = 1'b1;
        end
    end

    // Stage 2b: output register; wave and sat hold while no sample emerges.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            oValid_q <= 1'b0;
            oWave_q  <= '0;
            oSat_q   <= 1'b0;
        end else begin
            oValid_q <= s2Valid_q;
            if (s2Valid_q) begin
                oWave_q <= satWave;
                oSat_q  <= satFlag;
            end
        end
    end

    assign o_valid    = oValid_q;
    assign o_wave     = oWave_q;
    assign o_sat      = oSat_q;
    assign o_ramping  = ramping_q;
    assign o_cur_gain = curGain_q;

    // The applied gain must stay inside the supported range.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (curGain_q >= GAIN_LO) && (curGain_q <= GAIN_HI));

    // The applied gain never moves by more than one step per clock.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (curGain_d == curGain_q) ||
        (curGain_d == curGain_q + GAIN_W'(1)) ||
        (curGain_d == curGain_q - GAIN_W'(1)));

endmodule
